hazard_scoreboard: RTL and testbench

- Producer-side complement to the pipeline's MEM/WB forwarding mux.
- Tracks every in-flight register write issued from ID into EX, counting down the cycles until the result is forwardable.
- Raises a combinational stall for ID when a source is not yet forwardable (load-use, long-latency op), on WAW against a long op, or when the single long-latency unit is busy.
- Long-op completion arrives through a done handshake from the multi-cycle unit.

---
 rtl/hazard_scoreboard_pkg.sv | 27 ++
 rtl/hazard_scoreboard_if.sv | 34 +++
 rtl/hazard_scoreboard_sb_entry.sv | 39 +++
 rtl/hazard_scoreboard.sv | 89 ++++++++
 tb/tb_hazard_scoreboard.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: instruction class, register address width, entry record.
// Purely declarative; no latency or backpressure of its own.
package hazard_scoreboard_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int SB_CNT_W   = 3;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LOAD = 2'b01,
    CLS_LONG = 2'b10
  } id_class_e;

  typedef struct packed {
    logic                pend;
    logic                long_op;
    logic [SB_CNT_W-1:0] cnt;
  } sb_entry_t;

  // Encoding 2'b11 is reserved and behaves as a plain ALU op.
  function automatic id_class_e decode_class(input logic [1:0] raw);
    case (raw)
      2'b01:   return CLS_LOAD;
      2'b10:   return CLS_LONG;
      default: return CLS_ALU;
    endcase
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage / long-unit side of the scoreboard; master drives the instruction and completion, slave answers.
// Combinational answers (stall, issue) are valid in the same cycle as the request.
interface hazard_scoreboard_if #(parameter int NUM_REGS = 32);
  import hazard_scoreboard_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic                  id_rs1_used;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_we;
  logic [1:0]            id_class;
  logic                  ext_hold;
  logic                  lc_done;
  logic [REG_ADDR_W-1:0] lc_rd;
  logic                  stall;
  logic                  issue;
  logic [NUM_REGS-1:0]   pending_vec;
  logic                  long_busy;
  logic                  err_orphan_done;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_we, id_class,
    output ext_hold, lc_done, lc_rd,
    input  stall, issue, pending_vec, long_busy, err_orphan_done
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_we, id_class,
    input  ext_hold, lc_done, lc_rd,
    output stall, issue, pending_vec, long_busy, err_orphan_done
  );
endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's scoreboard entry: set on issue, counts a load down, cleared by long-op completion.
// State updates one edge after the request; no backpressure (caller has already resolved hazards).
module sb_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  id_class_e           set_cls,
  input  logic [SB_CNT_W-1:0] load_cnt,
  input  logic                done_clr,
  output sb_entry_t           ent
);
  sb_entry_t ent_d, ent_q;

  always_comb begin
    ent_d = ent_q;
    if (set_en) begin
      // A new write to this register always wins over a completion on the same edge.
      case (set_cls)
        CLS_LOAD: ent_d = '{pend: 1'b1, long_op: 1'b0, cnt: load_cnt};
        CLS_LONG: ent_d = '{pend: 1'b1, long_op: 1'b1, cnt: '0};
        default:  if (!ent_q.long_op || done_clr) ent_d = '0;
      endcase
    end else if (done_clr) begin
      ent_d = '0;
    end else if (ent_q.pend && !ent_q.long_op) begin
      if (ent_q.cnt != '0) ent_d.cnt = ent_q.cnt - 1'b1;
      else                 ent_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  assign ent = ent_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight register writes; raises combinational stall for RAW/WAW/long-unit-busy.
// Zero-latency stall/issue; ext_hold suppresses issue. Optional SCOREBOARD_DONE_BYPASS_EN releases in the done cycle.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = SB_CNT_W
) (
  input logic clk,
  input logic rst_n,
  hazard_scoreboard_if.slave sb
);
  if (CNT_W != SB_CNT_W || LOAD_STALL >= (1 << CNT_W)) begin : g_cfg_err
    $error("hazard_scoreboard: unsupported CNT_W/LOAD_STALL combination");
  end

  localparam logic [SB_CNT_W-1:0] LOAD_CNT = SB_CNT_W'(LOAD_STALL);

  sb_entry_t ent [NUM_REGS];
  id_class_e cls;
  logic      done_match, byp_rs1, byp_rs2, byp_rd;
  logic      raw_1, raw_2, waw, struct_haz, stall_w, issue_w;
  logic      long_busy_d, long_busy_q, err_d, err_q;

  assign ent[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
    sb_entry u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue_w && sb.id_we && (sb.id_rd == REG_ADDR_W'(r))),
      .set_cls  (cls),
      .load_cnt (LOAD_CNT),
      .done_clr (done_match && (sb.lc_rd == REG_ADDR_W'(r))),
      .ent      (ent[r])
    );
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pvec
    assign sb.pending_vec[r] = ent[r].pend;
  end

  assign cls        = decode_class(sb.id_class);
  assign done_match = sb.lc_done && (sb.lc_rd != '0) && ent[sb.lc_rd].pend && ent[sb.lc_rd].long_op;

`ifdef SCOREBOARD_DONE_BYPASS_EN
  // The long unit's output bypass supplies the result in the done cycle itself.
  assign byp_rs1 = done_match && (sb.lc_rd == sb.id_rs1);
  assign byp_rs2 = done_match && (sb.lc_rd == sb.id_rs2);
  assign byp_rd  = done_match && (sb.lc_rd == sb.id_rd);
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
  assign byp_rd  = 1'b0;
`endif

  always_comb begin
    raw_1 = sb.id_rs1_used && (sb.id_rs1 != '0) && ent[sb.id_rs1].pend &&
            (ent[sb.id_rs1].long_op || ent[sb.id_rs1].cnt != '0) && !byp_rs1;
    raw_2 = sb.id_rs2_used && (sb.id_rs2 != '0) && ent[sb.id_rs2].pend &&
            (ent[sb.id_rs2].long_op || ent[sb.id_rs2].cnt != '0) && !byp_rs2;
    waw   = sb.id_we && (sb.id_rd != '0) && ent[sb.id_rd].pend && ent[sb.id_rd].long_op && !byp_rd;
    // A completing long op frees the unit for a new LONG in the same cycle.
    struct_haz = (cls == CLS_LONG) && long_busy_q && !sb.lc_done;
    stall_w    = sb.id_valid && (raw_1 || raw_2 || waw || struct_haz);
    issue_w    = sb.id_valid && !stall_w && !sb.ext_hold;

    long_busy_d = long_busy_q;
    if (issue_w && cls == CLS_LONG) long_busy_d = 1'b1;
    else if (done_match)            long_busy_d = 1'b0;
    err_d = err_q || (sb.lc_done && !done_match);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_busy_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      long_busy_q <= long_busy_d;
      err_q       <= err_d;
    end
  end

  assign sb.stall           = stall_w;
  assign sb.issue           = issue_w;
  assign sb.long_busy       = long_busy_q;
  assign sb.err_orphan_done = err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, ALU forwarding, long ops, structural, orphan, hold, reset.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  hazard_scoreboard_if #(.NUM_REGS(32)) ifc ();

  hazard_scoreboard #(.NUM_REGS(32), .LOAD_STALL(1), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic we, input logic [1:0] cls);
    ifc.id_valid = v;   ifc.id_rs1 = rs1; ifc.id_rs1_used = u1;
    ifc.id_rs2 = rs2;   ifc.id_rs2_used = u2;
    ifc.id_rd = rd;     ifc.id_we = we;   ifc.id_class = cls;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00);
    ifc.lc_done = 1'b0; ifc.lc_rd = 5'd0; ifc.ext_hold = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #3;
    total++; if (ifc.stall !== 1'b0) begin bad++; $display("FAIL rst_stall act=%0b exp=0", ifc.stall); end
    total++; if (ifc.issue !== 1'b0) begin bad++; $display("FAIL rst_issue act=%0b exp=0", ifc.issue); end
    total++; if (ifc.pending_vec !== 32'h0) begin bad++; $display("FAIL rst_pvec act=%h exp=0", ifc.pending_vec); end
    total++; if (ifc.long_busy !== 1'b0) begin bad++; $display("FAIL rst_busy act=%0b exp=0", ifc.long_busy); end
    total++; if (ifc.err_orphan_done !== 1'b0) begin bad++; $display("FAIL rst_err act=%0b exp=0", ifc.err_orphan_done); end
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    step(); drv(1, 0, 0, 0, 0, 5, 1, 2'b01); #1;
    total++; if (ifc.issue !== 1'b1) begin bad++; $display("FAIL ld_issue act=%0b exp=1", ifc.issue); end
    step(); drv(1, 5, 1, 0, 0, 6, 1, 2'b00); #1;
    total++; if (ifc.stall !== 1'b1) begin bad++; $display("FAIL ld_use_stall act=%0b exp=1", ifc.stall); end
    total++; if (ifc.pending_vec[5] !== 1'b1) begin bad++; $display("FAIL ld_pend act=%0b exp=1", ifc.pending_vec[5]); end
    step(); #1;
    total++; if (ifc.issue !== 1'b1 || ifc.stall !== 1'b0) begin bad++; $display("FAIL ld_release issue=%0b stall=%0b exp 1/0", ifc.issue, ifc.stall); end
    step(); idle(); #1;
    total++; if (ifc.pending_vec !== 32'h0) begin bad++; $display("FAIL ld_clear act=%h exp=0", ifc.pending_vec); end
  endtask

  task automatic test_alu_fwd();
    step(); drv(1, 0, 0, 0, 0, 7, 1, 2'b00); #1;
    total++; if (ifc.issue !== 1'b1) begin bad++; $display("FAIL alu_issue act=%0b exp=1", ifc.issue); end
    step(); drv(1, 7, 1, 7, 1, 8, 1, 2'b11); #1;
    total++; if (ifc.stall !== 1'b0 || ifc.pending_vec[7] !== 1'b0) begin bad++; $display("FAIL alu_fwd stall=%0b pv7=%0b exp 0/0", ifc.stall, ifc.pending_vec[7]); end
    step(); idle(); #1;
    total++; if (ifc.pending_vec !== 32'h0) begin bad++; $display("FAIL alu_pvec act=%h exp=0", ifc.pending_vec); end
  endtask

  task automatic test_long();
    int   nstall;
    logic exp_done_stall;
`ifdef SCOREBOARD_DONE_BYPASS_EN
    exp_done_stall = 1'b0;
`else
    exp_done_stall = 1'b1;
`endif
    nstall = 0;
    step(); drv(1, 0, 0, 0, 0, 9, 1, 2'b10); #1;
    total++; if (ifc.issue !== 1'b1) begin bad++; $display("FAIL long_issue act=%0b exp=1", ifc.issue); end
    step(); drv(1, 0, 0, 9, 1, 0, 0, 2'b00); #1;
    total++; if (ifc.long_busy !== 1'b1 || ifc.pending_vec[9] !== 1'b1) begin bad++; $display("FAIL long_busy busy=%0b pv9=%0b exp 1/1", ifc.long_busy, ifc.pending_vec[9]); end
    if (ifc.stall === 1'b1) nstall++;
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      if (ifc.stall === 1'b1) nstall++;
    end
    total++; if (nstall !== 9) begin bad++; $display("FAIL long_wait stalls=%0d exp=9", nstall); end
    step(); ifc.lc_done = 1'b1; ifc.lc_rd = 5'd9; #1;
    total++; if (ifc.stall !== exp_done_stall) begin bad++; $display("FAIL long_done_stall act=%0b exp=%0b", ifc.stall, exp_done_stall); end
    step(); ifc.lc_done = 1'b0; #1;
    total++; if (ifc.stall !== 1'b0 || ifc.issue !== 1'b1) begin bad++; $display("FAIL long_release stall=%0b issue=%0b exp 0/1", ifc.stall, ifc.issue); end
    total++; if (ifc.long_busy !== 1'b0 || ifc.pending_vec[9] !== 1'b0) begin bad++; $display("FAIL long_clear busy=%0b pv9=%0b exp 0/0", ifc.long_busy, ifc.pending_vec[9]); end
    step(); idle();
  endtask

  task automatic test_struct();
    step(); drv(1, 0, 0, 0, 0, 10, 1, 2'b10); #1;
    total++; if (ifc.issue !== 1'b1) begin bad++; $display("FAIL st_first act=%0b exp=1", ifc.issue); end
    step(); drv(1, 0, 0, 0, 0, 11, 1, 2'b10); #1;
    total++; if (ifc.stall !== 1'b1) begin bad++; $display("FAIL st_busy_stall act=%0b exp=1", ifc.stall); end
    step(); step(); #1;
    total++; if (ifc.stall !== 1'b1 || ifc.issue !== 1'b0) begin bad++; $display("FAIL st_held stall=%0b issue=%0b exp 1/0", ifc.stall, ifc.issue); end
    step(); ifc.lc_done = 1'b1; ifc.lc_rd = 5'd10; #1;
    total++; if (ifc.issue !== 1'b1 || ifc.stall !== 1'b0) begin bad++; $display("FAIL st_done_issue issue=%0b stall=%0b exp 1/0", ifc.issue, ifc.stall); end
    step(); idle(); ifc.lc_done = 1'b1; ifc.lc_rd = 5'd11; #1;
    total++; if (ifc.long_busy !== 1'b1) begin bad++; $display("FAIL st_busy_kept act=%0b exp=1", ifc.long_busy); end
    total++; if (ifc.pending_vec !== 32'h0000_0800) begin bad++; $display("FAIL st_pvec act=%h exp=00000800", ifc.pending_vec); end
    step(); ifc.lc_done = 1'b0; #1;
    total++; if (ifc.long_busy !== 1'b0 || ifc.pending_vec !== 32'h0) begin bad++; $display("FAIL st_final busy=%0b pv=%h exp 0/0", ifc.long_busy, ifc.pending_vec); end
  endtask

  task automatic test_orphan();
    step(); ifc.lc_done = 1'b1; ifc.lc_rd = 5'd3; #1;
    total++; if (ifc.pending_vec !== 32'h0 || ifc.err_orphan_done !== 1'b0) begin bad++; $display("FAIL orph_pre pv=%h err=%0b exp 0/0", ifc.pending_vec, ifc.err_orphan_done); end
    step(); ifc.lc_done = 1'b0; #1;
    total++; if (ifc.err_orphan_done !== 1'b1) begin bad++; $display("FAIL orph_set act=%0b exp=1", ifc.err_orphan_done); end
    step(); drv(1, 0, 0, 0, 0, 0, 1, 2'b01); #1;
    total++; if (ifc.err_orphan_done !== 1'b1) begin bad++; $display("FAIL orph_sticky act=%0b exp=1", ifc.err_orphan_done); end
    total++; if (ifc.issue !== 1'b1 || ifc.stall !== 1'b0) begin bad++; $display("FAIL x0_load issue=%0b stall=%0b exp 1/0", ifc.issue, ifc.stall); end
    step(); drv(1, 0, 1, 0, 1, 4, 1, 2'b00); #1;
    total++; if (ifc.stall !== 1'b0 || ifc.pending_vec !== 32'h0) begin bad++; $display("FAIL x0_read stall=%0b pv=%h exp 0/0", ifc.stall, ifc.pending_vec); end
    step(); idle();
  endtask

  task automatic test_ext_hold();
    step(); drv(1, 0, 0, 0, 0, 5, 1, 2'b01); #1;
    total++; if (ifc.issue !== 1'b1) begin bad++; $display("FAIL hold_ld_issue act=%0b exp=1", ifc.issue); end
    step(); drv(1, 5, 1, 0, 0, 6, 1, 2'b00); ifc.ext_hold = 1'b1; #1;
    total++; if (ifc.stall !== 1'b1 || ifc.issue !== 1'b0) begin bad++; $display("FAIL hold_stall stall=%0b issue=%0b exp 1/0", ifc.stall, ifc.issue); end
    step(); #1;
    total++; if (ifc.stall !== 1'b0 || ifc.issue !== 1'b0) begin bad++; $display("FAIL hold_block stall=%0b issue=%0b exp 0/0", ifc.stall, ifc.issue); end
    step(); ifc.ext_hold = 1'b0; #1;
    total++; if (ifc.issue !== 1'b1 || ifc.pending_vec[5] !== 1'b0) begin bad++; $display("FAIL hold_release issue=%0b pv5=%0b exp 1/0", ifc.issue, ifc.pending_vec[5]); end
    step(); idle();
  endtask

  task automatic test_reset_mid();
    step(); drv(1, 0, 0, 0, 0, 12, 1, 2'b10); #1;
    total++; if (ifc.issue !== 1'b1) begin bad++; $display("FAIL rm_long act=%0b exp=1", ifc.issue); end
    step(); drv(1, 0, 0, 0, 0, 5, 1, 2'b01); #1;
    total++; if (ifc.issue !== 1'b1) begin bad++; $display("FAIL rm_load act=%0b exp=1", ifc.issue); end
    step(); idle(); #1;
    total++; if (ifc.pending_vec !== 32'h0000_1020 || ifc.long_busy !== 1'b1) begin bad++; $display("FAIL rm_pre pv=%h busy=%0b exp 00001020/1", ifc.pending_vec, ifc.long_busy); end
    rst_n = 1'b0; #1;
    total++; if (ifc.pending_vec !== 32'h0 || ifc.long_busy !== 1'b0 || ifc.err_orphan_done !== 1'b0) begin bad++; $display("FAIL rm_async pv=%h busy=%0b err=%0b exp 0/0/0", ifc.pending_vec, ifc.long_busy, ifc.err_orphan_done); end
    total++; if (ifc.stall !== 1'b0 || ifc.issue !== 1'b0) begin bad++; $display("FAIL rm_outs stall=%0b issue=%0b exp 0/0", ifc.stall, ifc.issue); end
    step(); step(); rst_n = 1'b1;
    step(); drv(1, 5, 1, 12, 1, 6, 1, 2'b00); #1;
    total++; if (ifc.stall !== 1'b0 || ifc.issue !== 1'b1) begin bad++; $display("FAIL rm_after stall=%0b issue=%0b exp 0/1", ifc.stall, ifc.issue); end
    step(); idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_long();
    test_struct();
    test_orphan();
    test_ext_hold();
    test_reset_mid();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
